rx_frame_sync: RTL and testbench

RX_FRAME_SYNC -- requirements
Module: rx_frame_sync

---
 rtl/rx_sync_pkg.sv | 24 ++
 rtl/rx_frame_sync_if.sv | 25 ++
 rtl/rx_sync_match.sv | 18 +
 rtl/rx_frame_sync.sv | 163 ++++++++++++++++
 tb/tb_rx_frame_sync.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_sync_pkg.sv
// Shared types and constants for the RX frame synchroniser.
package rx_sync_pkg;

   localparam int unsigned SYNC_W     = 32;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BIT_CNT_W  = 5;
   localparam int unsigned BYTE_CNT_W = 8;
   localparam int unsigned MISS_CNT_W = 4;

   localparam logic [SYNC_W-1:0] SYNC_WORD_DEFAULT = 32'h1ACF_FC1D;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } rx_state_e;

   // Output byte register contents.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } rx_byte_t;

endpackage

// File: rtl/rx_frame_sync_if.sv
// Bit-stream input and byte-stream output handshakes of the frame synchroniser.
interface rx_frame_sync_if;
   import rx_sync_pkg::*;

   logic              in_valid;
   logic              in_data;
   logic              in_ready;
   logic              out_valid;
   logic [BYTE_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   // Environment side: supplies demodulated bits, consumes payload bytes.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // Framer side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/rx_sync_match.sv
// Compares a 32-bit window against the sync marker in both polarities.
module rx_sync_match
   import rx_sync_pkg::*;
#(
   parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
   input  logic [SYNC_W-1:0] word,
   output logic              match,
   output logic              match_inv
);

   // Straight and bit-inverted marker detection.
   always_comb begin
      match     = (word == SYNC_WORD);
      match_inv = (word == ~SYNC_WORD);
   end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: hunts for the sync marker in a hard-bit stream,
// delivers payload bytes, and flywheels through a bounded number of
// missed markers before dropping lock.
module rx_frame_sync
   import rx_sync_pkg::*;
#(
   parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
   parameter int unsigned       PAYLOAD_BYTES = 16,
   parameter int unsigned       MAX_MISS      = 3
) (
   input  logic           clk,
   input  logic           rst,
   rx_frame_sync_if.slave bus,
   output logic           locked,
   output logic           inverted
);

   rx_state_e               state_q, state_nxt;
   logic [SYNC_W-1:0]       sr_q, sr_nxt;
   logic [BYTE_W-2:0]       acc_q, acc_nxt;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_nxt;
   logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_nxt;
   logic [MISS_CNT_W-1:0]   miss_q, miss_nxt;
   rx_byte_t                obuf_q, obuf_nxt;
   logic                    out_valid_q, out_valid_nxt;
   logic                    inverted_q, inverted_nxt;
   logic                    locked_q, locked_nxt;

   logic                    in_ready_c;
   logic                    beat_c;
   logic [SYNC_W-1:0]       sr_shift_c;
   logic                    sync_hit_c;
   logic                    sync_hit_inv_c;
   logic                    check_hit_c;
   logic [BYTE_W-1:0]       byte_c;
   logic                    last_byte_c;
   logic [MISS_CNT_W-1:0]   miss_inc_c;

   // Single output register: accept bits whenever the register is free or draining.
   assign in_ready_c = ~out_valid_q | bus.out_ready;
   assign beat_c     = bus.in_valid & in_ready_c;
   assign sr_shift_c = {sr_q[SYNC_W-2:0], bus.in_data};

   rx_sync_match #(
      .SYNC_WORD (SYNC_WORD)
   ) u_match (
      .word      (sr_shift_c),
      .match     (sync_hit_c),
      .match_inv (sync_hit_inv_c)
   );

   // Datapath helpers: payload bit de-inversion, last-byte flag, missed-marker count.
   always_comb begin
      check_hit_c = inverted_q ? sync_hit_inv_c : sync_hit_c;
      byte_c      = {acc_q, bus.in_data ^ inverted_q};
      last_byte_c = (byte_cnt_q == BYTE_CNT_W'(PAYLOAD_BYTES - 1));
      miss_inc_c  = miss_q + MISS_CNT_W'(1);
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt     = state_q;
      sr_nxt        = sr_q;
      acc_nxt       = acc_q;
      bit_cnt_nxt   = bit_cnt_q;
      byte_cnt_nxt  = byte_cnt_q;
      miss_nxt      = miss_q;
      obuf_nxt      = obuf_q;
      out_valid_nxt = out_valid_q;
      inverted_nxt  = inverted_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_nxt = 1'b0;
      end

      if (beat_c) begin
         sr_nxt = sr_shift_c;
         unique case (state_q)
            ST_HUNT: begin
               if (sync_hit_c || sync_hit_inv_c) begin
                  state_nxt    = ST_PAYLOAD;
                  inverted_nxt = sync_hit_inv_c;
                  bit_cnt_nxt  = '0;
                  byte_cnt_nxt = '0;
               end
            end
            ST_PAYLOAD: begin
               acc_nxt = byte_c[BYTE_W-2:0];
               if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                  bit_cnt_nxt   = '0;
                  obuf_nxt.data = byte_c;
                  obuf_nxt.last = last_byte_c;
                  out_valid_nxt = 1'b1;
                  if (last_byte_c) begin
                     byte_cnt_nxt = '0;
                     state_nxt    = ST_CHECK;
                  end else begin
                     byte_cnt_nxt = byte_cnt_q + BYTE_CNT_W'(1);
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            ST_CHECK: begin
               if (bit_cnt_q == BIT_CNT_W'(SYNC_W - 1)) begin
                  bit_cnt_nxt = '0;
                  if (check_hit_c) begin
                     miss_nxt  = '0;
                     state_nxt = ST_PAYLOAD;
                  end else if (miss_inc_c == MISS_CNT_W'(MAX_MISS)) begin
                     miss_nxt     = '0;
                     inverted_nxt = 1'b0;
                     state_nxt    = ST_HUNT;
                  end else begin
                     miss_nxt  = miss_inc_c;
                     state_nxt = ST_PAYLOAD;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end

      locked_nxt = (state_nxt != ST_HUNT);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_HUNT;
         sr_q        <= '0;
         acc_q       <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         miss_q      <= '0;
         obuf_q      <= '0;
         out_valid_q <= 1'b0;
         inverted_q  <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         sr_q        <= sr_nxt;
         acc_q       <= acc_nxt;
         bit_cnt_q   <= bit_cnt_nxt;
         byte_cnt_q  <= byte_cnt_nxt;
         miss_q      <= miss_nxt;
         obuf_q      <= obuf_nxt;
         out_valid_q <= out_valid_nxt;
         inverted_q  <= inverted_nxt;
         locked_q    <= locked_nxt;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = obuf_q.data;
   assign bus.out_last  = obuf_q.last;
   assign locked        = locked_q;
   assign inverted      = inverted_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed bench for rx_frame_sync: table of whole-frame vectors plus
// hand-written sequences for miss/flywheel, backpressure, reset and straddled sync.
module tb_rx_frame_sync;
   import rx_sync_pkg::*;

   localparam logic [31:0] SYNC   = 32'h1ACF_FC1D;
   localparam int unsigned NBYTES = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked;
   logic inverted;
   int   rdy_mode = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [8:0] rx_q[$];
   logic [8:0] exp_q[$];

   rx_frame_sync_if bus ();

   rx_frame_sync #(
      .SYNC_WORD     (SYNC),
      .PAYLOAD_BYTES (NBYTES),
      .MAX_MISS      (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .locked   (locked),
      .inverted (inverted)
   );

   always #5 clk = ~clk;

   // Downstream readiness pattern: 0 = always ready, 1 = toggle, other = held low.
   always @(negedge clk) begin
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ~bus.out_ready;
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Collect every accepted byte as {last, data}.
   always @(posedge clk) begin
      if (rst && bus.out_valid && bus.out_ready)
         rx_q.push_back({bus.out_last, bus.out_data});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic send_bit(input logic b);
      int tries = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      #1;
      while (!bus.in_ready && tries < 200) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (!bus.in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL stall_timeout: in_ready got 0, expected 1 within 200 cycles");
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_payload(input logic [7:0] base, input logic inv);
      for (int i = 0; i < NBYTES; i++) send_word({24'h0, 8'(base + 8'(i)) ^ {8{inv}}}, 8);
   endtask

   task automatic send_frame(input logic [31:0] sync, input logic [7:0] base, input logic inv);
      send_word(sync ^ {32{inv}}, 32);
      send_payload(base, inv);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic push_frame(input logic [7:0] base, input int count);
      for (int i = 0; i < count; i++) exp_q.push_back({1'(i == NBYTES - 1), 8'(base + 8'(i))});
   endtask

   task automatic compare_q(input string name);
      check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
   endtask

   typedef struct {
      logic [31:0] sync_tx;
      logic        inv_tx;
      logic [7:0]  base;
      int          exp_bytes;
      logic        exp_locked;
      logic        exp_inv;
   } vec_t;

   vec_t       vecs[4];
   logic [31:0] sw;
   logic [7:0]  held_data;
   logic        held_seen;

   initial begin
      vecs[0] = '{32'h1ACF_FC1D, 1'b0, 8'h00, 16, 1'b1, 1'b0};
      vecs[1] = '{32'h1ACF_FC1D, 1'b1, 8'h00, 16, 1'b1, 1'b1};
      vecs[2] = '{32'h1ACF_FC1D, 1'b0, 8'hA0, 16, 1'b1, 1'b0};
      vecs[3] = '{32'hDEAD_BEEF, 1'b0, 8'h00, 0,  1'b0, 1'b0};

      bus.in_valid = 1'b0;
      bus.in_data  = 1'b0;

      // Reset values while reset is held.
      #1 rst = 1'b0;
      #2;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_inverted", 32'(inverted), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Whole-frame vectors.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         push_frame(vecs[v].base, vecs[v].exp_bytes);
         send_frame(vecs[v].sync_tx, vecs[v].base, vecs[v].inv_tx);
         idle(4);
         compare_q($sformatf("vec%0d", v));
         check($sformatf("vec%0d_locked", v), 32'(locked), 32'(vecs[v].exp_locked));
         check($sformatf("vec%0d_inverted", v), 32'(inverted), 32'(vecs[v].exp_inv));
      end

      // Flywheel through two missed markers, lose lock on the third.
      do_reset();
      push_frame(8'h10, NBYTES);
      push_frame(8'h20, NBYTES);
      push_frame(8'h30, NBYTES);
      send_frame(SYNC, 8'h10, 1'b0);
      send_frame(32'h0, 8'h20, 1'b0);
      send_frame(32'h0, 8'h30, 1'b0);
      idle(2);
      check("miss2_locked", 32'(locked), 32'd1);
      send_word(32'h0, 32);
      idle(2);
      check("miss3_locked", 32'(locked), 32'd0);
      check("miss3_inverted", 32'(inverted), 32'd0);
      send_payload(8'h40, 1'b0);
      idle(4);
      compare_q("miss");
      check("miss_hunt_locked", 32'(locked), 32'd0);

      // Downstream backpressure: toggle, then hold low for 10 cycles mid-frame.
      do_reset();
      push_frame(8'h50, NBYTES);
      rdy_mode = 1;
      fork
         send_frame(SYNC, 8'h50, 1'b0);
         begin
            for (int w = 0; w < 3000 && rx_q.size() < 5; w++) @(negedge clk);
            check("bp_wait5", 32'(rx_q.size() >= 5), 32'd1);
            rdy_mode = 2;
            held_seen = 1'b0;
            held_data = 8'h00;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               #2;
               if (bus.out_valid && !held_seen) begin
                  held_seen = 1'b1;
                  held_data = bus.out_data;
               end
            end
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_data", 32'(bus.out_data), 32'(held_data));
            rdy_mode = 1;
         end
      join
      rdy_mode = 0;
      idle(20);
      compare_q("bp");

      // Reset in the middle of byte 6.
      do_reset();
      send_word(SYNC, 32);
      for (int i = 0; i < 5; i++) send_word(32'(8'h60 + 8'(i)), 8);
      send_word(32'h5, 3);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      check("mid_bytes_before_rst", 32'(rx_q.size()), 32'd5);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      check("mid_rst_out_last", 32'(bus.out_last), 32'd0);
      check("mid_rst_locked", 32'(locked), 32'd0);
      check("mid_rst_inverted", 32'(inverted), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      rx_q.delete();
      for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
      idle(4);
      check("mid_rand_bytes", 32'(rx_q.size()), 32'd0);
      check("mid_rand_locked", 32'(locked), 32'd0);

      // Sync marker straddling preceding random data, no gap.
      do_reset();
      push_frame(8'h7A, NBYTES);
      sw = SYNC;
      send_word(32'h000A_5F3C, 20);
      for (int i = 31; i >= 1; i--) send_bit(sw[i]);
      @(posedge clk);
      #1;
      check("straddle_locked_31", 32'(locked), 32'd0);
      send_bit(sw[0]);
      @(posedge clk);
      #1;
      check("straddle_locked_32", 32'(locked), 32'd1);
      send_payload(8'h7A, 1'b0);
      idle(4);
      compare_q("straddle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
